// File: rtl/deserializer_unit_cell_16.sv
// deserializer_unit_cell_16
//   Receive-side 16-bit deserializer. Samples SERIAL_IN once per CLK. A frame
//   starts on FRAME_SYNC and ends after 16 bits, when the word is presented on
//   PAR_OUT together with a one-cycle PAR_VALID strobe.
//
// Parameters
//   CONTINUOUS : 1 = after a completed frame, the next bit starts a new frame
//                without needing FRAME_SYNC.
//   MSB_FIRST  : 1 = first received bit lands in PAR_OUT[15];
//                0 = first received bit lands in PAR_OUT[0].
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous, active-high
//   SERIAL_IN  in   serial data bit
//   FRAME_SYNC in   high while bit 0 of a frame is on SERIAL_IN
//   PAR_OUT    out  16  last completed word (held until the next word)
//   PAR_VALID  out  one-cycle pulse when PAR_OUT is updated
//   FRAME_ERR  out  one-cycle pulse when a mid-frame sync drops a partial frame
//   COUNT      out  5   bits captured in the current frame, 0 when idle
//   BUSY       out  high while a frame is in progress
module deserializer_unit_cell_16 #(
  parameter bit CONTINUOUS = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SERIAL_IN,
  input  logic        FRAME_SYNC,
  output logic [15:0] PAR_OUT,
  output logic        PAR_VALID,
  output logic        FRAME_ERR,
  output logic [4:0]  COUNT,
  output logic        BUSY
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] par_q, par_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // MSB-first shifts left with the new bit into the LSB, so after 16 bits the
  // first bit sits in [15]. LSB-first is the mirror image.
  function automatic logic [15:0] shift_in(input logic [15:0] cur, input logic b);
    return MSB_FIRST ? {cur[14:0], b} : {b, cur[15:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (FRAME_SYNC) begin
          shreg_d = shift_in(16'h0000, SERIAL_IN);
          count_d = 5'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (FRAME_SYNC && count_q != 5'd0) begin
          // Sync inside a frame (including at bit 15): drop the partial word
          // and restart with this bit as bit 0.
          err_d   = 1'b1;
          shreg_d = shift_in(16'h0000, SERIAL_IN);
          count_d = 5'd1;
        end else if (count_q == 5'd0) begin
          // Only reachable in continuous mode: frame boundary, sync optional.
          shreg_d = shift_in(16'h0000, SERIAL_IN);
          count_d = 5'd1;
        end else if (count_q == 5'd15) begin
          shreg_d = shift_in(shreg_q, SERIAL_IN);
          par_d   = shreg_d;
          valid_d = 1'b1;
          count_d = 5'd0;
          state_d = CONTINUOUS ? SHIFT : IDLE;
        end else begin
          shreg_d = shift_in(shreg_q, SERIAL_IN);
          count_d = count_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      shreg_q <= 16'h0000;
      par_q   <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign PAR_OUT   = par_q;
  assign PAR_VALID = valid_q;
  assign FRAME_ERR = err_q;
  assign COUNT     = count_q;
  assign BUSY      = (state_q == SHIFT);

endmodule

// File: tb/tb_deserializer_unit_cell_16.sv
// Bench for deserializer_unit_cell_16. Three instances share the serial
// stimulus: [0] defaults, [1] CONTINUOUS=1, [2] MSB_FIRST=0. A frame-level
// reference model (bit lists per frame) predicts every output of each.
module tb_deserializer_unit_cell_16;

  logic CLK = 1'b0;
  logic RESET, SERIAL_IN, FRAME_SYNC;
  logic [15:0] par [3];
  logic        pv  [3];
  logic        fe  [3];
  logic [4:0]  cn  [3];
  logic        bz  [3];
  logic [23:0] act [3];

  always #5 CLK = ~CLK;

  deserializer_unit_cell_16 #(.CONTINUOUS(1'b0), .MSB_FIRST(1'b1)) dut0 (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .FRAME_SYNC(FRAME_SYNC),
    .PAR_OUT(par[0]), .PAR_VALID(pv[0]), .FRAME_ERR(fe[0]), .COUNT(cn[0]), .BUSY(bz[0]));
  deserializer_unit_cell_16 #(.CONTINUOUS(1'b1), .MSB_FIRST(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .FRAME_SYNC(FRAME_SYNC),
    .PAR_OUT(par[1]), .PAR_VALID(pv[1]), .FRAME_ERR(fe[1]), .COUNT(cn[1]), .BUSY(bz[1]));
  deserializer_unit_cell_16 #(.CONTINUOUS(1'b0), .MSB_FIRST(1'b0)) dut2 (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .FRAME_SYNC(FRAME_SYNC),
    .PAR_OUT(par[2]), .PAR_VALID(pv[2]), .FRAME_ERR(fe[2]), .COUNT(cn[2]), .BUSY(bz[2]));

  // {PAR_OUT, PAR_VALID, FRAME_ERR, COUNT, BUSY}
  assign act[0] = {par[0], pv[0], fe[0], cn[0], bz[0]};
  assign act[1] = {par[1], pv[1], fe[1], cn[1], bz[1]};
  assign act[2] = {par[2], pv[2], fe[2], cn[2], bz[2]};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [1:0] stim [$];   // {sync, bit}

  // ---------------- reference model ----------------
  int          m_n   [3];      // bits received in current frame
  bit          m_act [3];      // a frame is open
  bit          m_b   [3][16];  // received bits in arrival order
  logic [15:0] m_par [3];
  bit          m_v   [3];
  bit          m_e   [3];

  function automatic bit cont_of(input int d); return d == 1; endfunction
  function automatic bit msbf_of(input int d); return d != 2; endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_n[d] = 0; m_act[d] = 0; m_par[d] = 16'h0; m_v[d] = 0; m_e[d] = 0;
    end
  endtask

  task automatic model_edge(input logic b, input logic s);
    for (int d = 0; d < 3; d++) begin
      m_v[d] = 0; m_e[d] = 0;
      if (s) begin
        if (m_n[d] != 0) m_e[d] = 1;
        m_n[d] = 0; m_act[d] = 1;
      end
      if (m_act[d]) begin
        m_b[d][m_n[d]] = b;
        m_n[d]++;
        if (m_n[d] == 16) begin
          for (int k = 0; k < 16; k++)
            m_par[d][msbf_of(d) ? 15 - k : k] = m_b[d][k];
          m_v[d] = 1; m_n[d] = 0; m_act[d] = cont_of(d);
        end
      end
    end
  endtask

  function automatic logic [23:0] exp_of(input int d);
    return {m_par[d], m_v[d], m_e[d], 5'(m_n[d]), m_act[d]};
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = w[15 - k];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic void push_bits(input logic [15:0] w, input int n, input bit sync_first);
    for (int k = 0; k < n; k++) stim.push_back({sync_first && k == 0, w[15 - k]});
  endfunction

  task automatic step(input logic b, input logic s);
    SERIAL_IN = b; FRAME_SYNC = s;
    @(posedge CLK);
    model_edge(b, s);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1; #2;
    model_reset();
    #2 RESET = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] w;
    logic [1:0] sv;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act[d] !== 24'h0) begin errors++; $display("FAIL reset_init dut%0d: got %h want 0", d, act[d]); end
    end
    RESET = 1'b0;
    model_reset();
    w = 16'($urandom);
    push_bits(w, 7, 1);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL reset_pre dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
    RESET = 1'b1; #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act[d] !== 24'h0) begin errors++; $display("FAIL reset_mid dut%0d: got %h want 0", d, act[d]); end
    end
    model_reset();
    #2 RESET = 1'b0;
    w = 16'($urandom);
    push_bits(w, 16, 1);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL reset_post dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
    checks++;
    if (par[0] !== w || pv[0] !== 1'b1) begin errors++; $display("FAIL reset_frame: got %h/%b want %h/1", par[0], pv[0], w); end
  endtask

  task automatic test_single();
    logic [1:0] sv;
    do_reset();
    push_bits(16'hC5AF, 16, 1);
    stim.push_back(2'b00);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL single dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
      if (stim.size() == 1) begin
        checks++;
        if (par[0] !== 16'hC5AF || par[2] !== 16'hF5A3 || pv[0] !== 1'b1)
          begin errors++; $display("FAIL single_word: got %h %h %b want c5af f5a3 1", par[0], par[2], pv[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sv;
    int vcyc [$];
    logic [15:0] vw [$];
    do_reset();
    push_bits(16'hC5AF, 16, 1);
    push_bits(16'h1234, 16, 1);
    stim.push_back(2'b00); stim.push_back(2'b00);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      if (pv[0]) begin vcyc.push_back(cyc); vw.push_back(par[0]); end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL b2b dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
    checks++;
    if (vcyc.size() != 2 || vcyc[1] - vcyc[0] != 16 || vw[0] !== 16'hC5AF || vw[1] !== 16'h1234)
      begin errors++; $display("FAIL b2b_pulses: got %0d pulses want 2 at 16-cycle spacing c5af,1234", vcyc.size()); end
  endtask

  task automatic test_misalign();
    logic [1:0] sv;
    int nerr, nval;
    logic [15:0] lastw;
    do_reset();
    nerr = 0; nval = 0; lastw = 16'h0;
    push_bits(16'($urandom), 5, 1);
    push_bits(16'hA5A5, 16, 1);
    push_bits(16'($urandom), 15, 1);   // sync landing at bit 15 is also mid-frame
    push_bits(16'h3C96, 16, 1);
    stim.push_back(2'b00);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      if (fe[0]) nerr++;
      if (pv[0]) begin nval++; lastw = par[0]; end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL misalign dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
      if (stim.size() == 32) begin
        checks++;
        if (nerr != 1 || nval != 1 || lastw !== 16'hA5A5)
          begin errors++; $display("FAIL misalign_a5a5: got err=%0d val=%0d w=%h want 1 1 a5a5", nerr, nval, lastw); end
      end
    end
    checks++;
    if (nerr != 2 || nval != 2 || lastw !== 16'h3C96)
      begin errors++; $display("FAIL misalign_b15: got err=%0d val=%0d w=%h want 2 2 3c96", nerr, nval, lastw); end
  endtask

  task automatic test_continuous();
    logic [1:0] sv;
    logic [15:0] got [$];
    int busy_low;
    do_reset();
    busy_low = 0;
    push_bits(16'h0001, 16, 1);
    push_bits(16'hFFFF, 16, 0);
    push_bits(16'h8000, 16, 0);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      if (pv[1]) got.push_back(par[1]);
      if (!bz[1]) busy_low++;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL cont dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
    checks++;
    if (got.size() != 3 || got[0] !== 16'h0001 || got[1] !== 16'hFFFF || got[2] !== 16'h8000 || busy_low != 0)
      begin errors++; $display("FAIL cont_words: got %0d words busy_low=%0d want 3 words 0001,ffff,8000 busy_low=0", got.size(), busy_low); end
  endtask

  task automatic test_idle_noise();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom), 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL idle dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
    checks++;
    if (par[0] !== 16'h0 || cn[0] !== 5'd0 || pv[0] !== 1'b0)
      begin errors++; $display("FAIL idle_end: got par=%h cnt=%0d want 0 0", par[0], cn[0]); end
  endtask

  task automatic test_random();
    logic [1:0] sv;
    int r;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) push_bits(16'($urandom), 16, 1);
      else if (r == 1) push_bits(16'($urandom), $urandom_range(1, 15), 1);
      else push_bits(16'($urandom), $urandom_range(1, 3), 0);
    end
    push_bits(16'($urandom), 16, 1);
    while (stim.size() > 0) begin
      sv = stim.pop_front(); step(sv[0], sv[1]);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_of(d)) begin errors++; $display("FAIL random dut%0d cyc=%0d: got %h want %h", d, cyc, act[d], exp_of(d)); end
      end
    end
  endtask

  initial begin
    RESET = 1'b1; SERIAL_IN = 1'b0; FRAME_SYNC = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_misalign();
    test_continuous();
    test_idle_noise();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
